// File: rtl/cpu_fetch_queue.sv
// rtl/cpu_fetch_queue.sv - instruction queue between the fetch and decode stages
//
// Buffers fetched instruction words with their PCs in a circular buffer so an
// icache response is never lost while decode stalls. A redirect (flush) from
// execute discards every buffered entry.
//
// Optional feature macro: CPU_FETCH_QUEUE_BYPASS_EN
//   defined   - an empty queue forwards enq_instr/enq_pc straight to the deq
//               side in the same cycle (0-cycle latency); if decode takes it,
//               the entry is never written.
//   undefined - baseline 1-cycle latency, no forwarding path.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   enq_valid/ready     fetch-side handshake
//   enq_instr, enq_pc   instruction word and its PC from the icache response
//   flush               redirect from execute, drops all entries
//   deq_valid/ready     decode-side handshake
//   deq_instr, deq_pc   head entry toward decode
//   count               current occupancy (0..DEPTH)

module cpu_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  input  logic [XLEN-1:0]   enq_instr,
  input  logic [ADDR_W-1:0] enq_pc,
  output logic              enq_ready,
  input  logic              flush,
  output logic              deq_valid,
  output logic [XLEN-1:0]   deq_instr,
  output logic [ADDR_W-1:0] deq_pc,
  input  logic              deq_ready,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]   instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;

  logic empty;
  logic bypass;
  logic bypass_take;
  logic enq_fire;
  logic deq_fire;
  logic do_write;
  logic do_read;

  assign count = count_q;
  assign empty = (count_q == '0);

  // Ready depends only on stored occupancy, so a full queue refuses an
  // enqueue even when decode drains the head in the same cycle.
  assign enq_ready = !reset && (count_q != FULL_CNT);

`ifdef CPU_FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && enq_valid && !flush && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid = !reset && !flush && (!empty || bypass);
  assign deq_instr = bypass ? enq_instr : instr_mem[rd_ptr];
  assign deq_pc    = bypass ? enq_pc    : pc_mem[rd_ptr];

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  // A forwarded entry taken by decode never touches storage: both sides
  // handshake but neither the pointers nor the count move.
  assign bypass_take = bypass && deq_ready;
  assign do_write    = enq_fire && !bypass_take;
  assign do_read     = deq_fire && !bypass_take;

  // Control state: pointers and occupancy. Flush clears them exactly like
  // reset; stale entries left behind are unreachable.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage. Cleared on reset so the head outputs are never X, even
  // while deq_valid is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (do_write && !flush) begin
      instr_mem[wr_ptr] <= enq_instr;
      pc_mem[wr_ptr]    <= enq_pc;
    end
  end

endmodule
